// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   RESET_PC_DEFAULT : default PC loaded while reset is asserted
//   INSTR_WIDTH      : instruction word width
//   WORD_BYTES       : bytes per instruction word (PC stride)
//   fetch_entry_t    : {instr, pc} pair carried through the output buffer
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_WIDTH      = 32;
  localparam int          WORD_BYTES       = 4;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [31:0]            pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle for the fetch stage: BRAM read port, redirect request and the
// valid/ready output towards decode.
//   master : fetch_unit side (drives BRAM request and output pair)
//   slave  : environment side (BRAM, branch unit, decode)
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 18
);
  import fetch_unit_pkg::*;

  logic                   bram_enable;
  logic [ADDR_WIDTH-1:0]  bram_addr;
  logic [INSTR_WIDTH-1:0] bram_data;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [31:0]            out_pc;

  modport master (
    output bram_enable, bram_addr, out_valid, out_instr, out_pc,
    input  bram_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  bram_enable, bram_addr, out_valid, out_instr, out_pc,
    output bram_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_unit_buffer.sv
// Two-entry FIFO of {instr, pc} pairs with synchronous flush.
//   clk, n_reset : clock, async active-low reset
//   push_i       : write push_data_i at the clock edge
//   pop_i        : retire the head entry at the clock edge
//   flush_i      : drop all entries (wins over push and pop)
//   head_o       : oldest entry (meaningful only when count_o != 0)
//   count_o      : number of stored entries, 0..2
module fetch_unit_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         n_reset,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q,  count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// synchronous BRAM, pairs each returned word with its PC and hands the pair
// to decode over valid/ready. Redirect flushes everything in flight.
//   clk, n_reset : clock, async active-low reset
//   bus (master) : BRAM request/data, redirect request, output pair
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_WIDTH = 18,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          DEPTH      = 2
) (
  input  logic         clk,
  input  logic         n_reset,
  fetch_unit_if.master bus
);

  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic [1:0]   count;
  logic         out_valid;
  logic         pop;
  logic [2:0]   occupancy;
  logic         issue;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Credit: buffered + in flight, minus what leaves this cycle, must leave
  // room for the read we are about to issue. out_ready reaches issue
  // combinationally so a full buffer being drained keeps fetching at rate.
  assign occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = !bus.redirect_valid && (occupancy < 3'(DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~32'h3;
    end else if (issue) begin
      pc_d          = pc_q + 32'(WORD_BYTES);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{instr: bus.bram_data, pc: inflight_pc_q};

  // Flush on redirect also discards the word returning for the read that
  // was in flight, since the push is suppressed inside the buffer.
  fetch_unit_buffer u_buffer (
    .clk         (clk),
    .n_reset     (n_reset),
    .push_i      (inflight_q),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.bram_enable = n_reset && issue;
  assign bus.bram_addr   = pc_q[ADDR_WIDTH+1:2];
  assign bus.out_valid   = out_valid;
  assign bus.out_instr   = out_valid ? head.instr : '0;
  assign bus.out_pc      = out_valid ? head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int          AW       = 18;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // BRAM: word i holds 0xE000_0000 + i, one-cycle read latency
  always @(posedge clk)
    if (bus.bram_enable) bus.bram_data <= 32'hE000_0000 + 32'(bus.bram_addr);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hE000_0000 + {14'd0, pc[AW+1:2]};
  endfunction

  // Transaction model: list of reads issued but not yet accepted downstream.
  // A read becomes visible two cycles after issue; at most two may be
  // outstanding; redirect empties the list and retargets the fetch PC.
  typedef struct { logic [31:0] pc; int unsigned cyc; } iss_t;
  iss_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  int unsigned m_cyc = 0;
  bit          m_valid, m_pop, m_en;
  int          m_occ;

  always @(negedge clk) begin
    if (!n_reset) begin
      mq.delete();
      m_pc = RESET_PC;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_bram_enable", bus.bram_enable, 0);
    end else begin
      m_valid = (mq.size() > 0) && (m_cyc - mq[0].cyc >= 2);
      check("model_out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("model_out_pc", bus.out_pc, mq[0].pc);
        check("model_out_instr", bus.out_instr, word_at(mq[0].pc));
      end
      m_pop = m_valid && bus.out_ready;
      m_occ = mq.size() - (m_pop ? 1 : 0);
      m_en  = !bus.redirect_valid && (m_occ < 2);
      check("model_bram_enable", bus.bram_enable, m_en);
      check("model_bram_addr", bus.bram_addr, m_pc[AW+1:2]);
      if (m_pop) void'(mq.pop_front());
      if (bus.redirect_valid) begin
        mq.delete();
        m_pc = bus.redirect_pc & ~32'h3;
      end else if (m_en) begin
        mq.push_back('{pc: m_pc, cyc: m_cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    m_cyc++;
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // returns at the negedge of the first accepted transfer
  task automatic wait_accept(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) ok = 1;
    end
    if (!ok) begin
      bad++;
      total++;
      $display("FAIL %s: no transfer within 20 cycles", name);
    end
  endtask

  int en_cnt;
  bit ok;

  initial begin
    n_reset            = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (3) drive_edge();
    check("reset_out_pc", bus.out_pc, 32'h0);
    check("reset_out_instr", bus.out_instr, 32'h0);
    check("reset_bram_addr", bus.bram_addr, 18'h0);

    // Streaming from reset
    n_reset = 1'b1;
    @(negedge clk);
    check("t1_first_enable", bus.bram_enable, 1);
    check("t1_first_addr", bus.bram_addr, 18'h0);
    @(negedge clk);
    check("t1_not_yet_valid", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_stream_valid", bus.out_valid, 1);
      check("t1_stream_pc", bus.out_pc, 32'(i * 4));
      check("t1_stream_instr", bus.out_instr, 32'hE000_0000 + 32'(i));
    end

    // Reset mid-stream
    drive_edge();
    check("t6_valid_before_reset", bus.out_valid, 1);
    n_reset = 1'b0;
    #1;
    check("t6_valid_async_clear", bus.out_valid, 0);
    check("t6_enable_async_clear", bus.bram_enable, 0);
    repeat (2) drive_edge();

    // Backpressure from reset
    bus.out_ready = 1'b0;
    n_reset       = 1'b1;
    en_cnt        = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.bram_enable) en_cnt++;
    end
    check("t2_enable_pulses", en_cnt, 2);
    check("t2_hold_pc", bus.out_pc, 32'h0);
    check("t2_hold_instr", bus.out_instr, 32'hE000_0000);
    drive_edge();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_drain_valid", bus.out_valid, 1);
      check("t2_drain_pc", bus.out_pc, 32'(i * 4));
    end

    // Redirect while stalled
    drive_edge();
    bus.out_ready = 1'b0;
    repeat (4) drive_edge();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    drive_edge();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_redirect_enable", bus.bram_enable, 1);
    check("t3_redirect_addr", bus.bram_addr, 18'h40);
    drive_edge();
    bus.out_ready = 1'b1;
    wait_accept("t3_accept", ok);
    if (ok) begin
      check("t3_pc", bus.out_pc, 32'h0000_0100);
      check("t3_instr", bus.out_instr, 32'hE000_0040);
    end

    // Unaligned redirect target
    drive_edge();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    drive_edge();
    bus.redirect_valid = 1'b0;
    wait_accept("t4_accept", ok);
    if (ok) check("t4_pc", bus.out_pc, 32'h0000_0100);

    // Wrap at top of address space
    drive_edge();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    drive_edge();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_addr_top", bus.bram_addr, 18'h3FFFF);
    @(negedge clk);
    check("t5_addr_wrap", bus.bram_addr, 18'h0);
    wait_accept("t5_accept", ok);
    if (ok) begin
      check("t5_pc_top", bus.out_pc, 32'hFFFF_FFFC);
      check("t5_instr_top", bus.out_instr, 32'hE003_FFFF);
      @(negedge clk);
      check("t5_pc_wrap", bus.out_pc, 32'h0);
      check("t5_instr_wrap", bus.out_instr, 32'hE000_0000);
    end

    // Back-to-back redirects: last wins
    drive_edge();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    drive_edge();
    bus.redirect_pc    = 32'h0000_0300;
    drive_edge();
    bus.redirect_valid = 1'b0;
    wait_accept("t7_accept", ok);
    if (ok) check("t7_pc", bus.out_pc, 32'h0000_0300);

    // Mixed traffic, checked by the model
    for (int i = 0; i < 300; i++) begin
      drive_edge();
      bus.out_ready      = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      bus.redirect_pc    = $urandom;
    end
    drive_edge();
    bus.redirect_valid = 1'b0;
    repeat (3) drive_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
